// File: rtl/rtl_pkg.sv
// Shared RTL types: ALU op packet and BMU arbiter tag.
// Imported by the BMU arbiter and its round-robin sub-module.
package rtl_pkg;

    localparam int RTL_ALU_PKT_W = 42;
    localparam int BMU_ARB_MAX_REQ = 4;
    localparam int BMU_ARB_ID_W = 2;

    typedef logic [RTL_ALU_PKT_W-1:0] rtl_alu_pkt_t;

    typedef struct packed {
        logic                    valid;
        logic [BMU_ARB_ID_W-1:0] id;
    } bmu_tag_t;

endpackage

// File: rtl/bmu_rr_arbiter.sv
// Combinational round-robin grant with a registered priority pointer.
// Ports: clk, rst (async high), req[N], advance (grant taken), grant[N] one-hot.
module bmu_rr_arbiter
    import rtl_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [BMU_ARB_ID_W-1:0] ptr;
    logic [BMU_ARB_ID_W-1:0] ptr_nxt;
    logic                    found;
    int                      idx;

    // Scan from the pointer upward with wrap; the first requester wins and
    // the pointer moves just past it.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_nxt    = (idx == N - 1) ? '0 : BMU_ARB_ID_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/bmu_arbiter.sv
// Shares one BMU between NUM_REQ issue ports: round-robin grant, registered
// BMU issue bus, tag pipeline over the BMU latency, one response slot each.
// Ports: reqValid/reqReady/reqAp/reqA/reqB/reqCsrRen/reqCsrRdata (issue),
// rspValid/rspReady/rspResult/rspError (response), bmu* (BMU side).
module bmu_arbiter
    import rtl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int BMU_LATENCY = 1,
    parameter int ALU_PKT_W   = RTL_ALU_PKT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                reqValid,
    output logic [NUM_REQ-1:0]                reqReady,
    input  logic [NUM_REQ-1:0][ALU_PKT_W-1:0] reqAp,
    input  logic [NUM_REQ-1:0][31:0]          reqA,
    input  logic [NUM_REQ-1:0][31:0]          reqB,
    input  logic [NUM_REQ-1:0]                reqCsrRen,
    input  logic [NUM_REQ-1:0][31:0]          reqCsrRdata,
    output logic [NUM_REQ-1:0]                rspValid,
    input  logic [NUM_REQ-1:0]                rspReady,
    output logic [NUM_REQ-1:0][31:0]          rspResult,
    output logic [NUM_REQ-1:0]                rspError,
    output logic                              bmuValidIn,
    output logic [ALU_PKT_W-1:0]              bmuAp,
    output logic [31:0]                       bmuAIn,
    output logic [31:0]                       bmuBIn,
    output logic                              bmuCsrRenIn,
    output logic [31:0]                       bmuCsrRdataIn,
    output logic                              bmuScanMode,
    input  logic [31:0]                       bmuResultFf,
    input  logic                              bmuError
);

    logic [NUM_REQ-1:0]      inflight;
    logic [NUM_REQ-1:0]      rsp_full;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      arb_req;
    logic [NUM_REQ-1:0]      grant;
    logic                    any_grant;
    logic [BMU_ARB_ID_W-1:0] grant_id;
    logic [ALU_PKT_W-1:0]    sel_ap;
    logic [31:0]             sel_a;
    logic [31:0]             sel_b;
    logic                    sel_ren;
    logic [31:0]             sel_rdata;
    bmu_tag_t                tag_q [0:BMU_LATENCY];
    bmu_tag_t                tag_out;

    // One op outstanding per requester: in flight or parked in its slot.
    assign eligible  = reqValid & ~inflight & ~rsp_full;
    // Reset is asynchronous, so the combinational grant is masked as well.
    assign arb_req   = rst ? '0 : eligible;
    assign any_grant = |grant;
    assign reqReady  = grant;
    assign rspValid  = rsp_full;
    assign tag_out   = tag_q[BMU_LATENCY];
    assign bmuScanMode = 1'b0;

    bmu_rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .advance(any_grant),
        .grant  (grant)
    );

    // Selected fields stay zero without a grant, which keeps the issue bus
    // quiet on idle cycles.
    always_comb begin
        grant_id  = '0;
        sel_ap    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_ren   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id  = BMU_ARB_ID_W'(i);
                sel_ap    = reqAp[i];
                sel_a     = reqA[i];
                sel_b     = reqB[i];
                sel_ren   = reqCsrRen[i];
                sel_rdata = reqCsrRdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bmuValidIn    <= 1'b0;
            bmuAp         <= '0;
            bmuAIn        <= '0;
            bmuBIn        <= '0;
            bmuCsrRenIn   <= 1'b0;
            bmuCsrRdataIn <= '0;
        end else begin
            bmuValidIn    <= any_grant;
            bmuAp         <= sel_ap;
            bmuAIn        <= sel_a;
            bmuBIn        <= sel_b;
            bmuCsrRenIn   <= sel_ren;
            bmuCsrRdataIn <= sel_rdata;
        end
    end

    // Stage 0 lines up with bmuValidIn; the last stage lines up with the
    // BMU result for the same op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= BMU_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: any_grant, id: grant_id};
            for (int k = 1; k <= BMU_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight  <= '0;
            rsp_full  <= '0;
            rspResult <= '0;
            rspError  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_full[i] && rspReady[i]) begin
                    rsp_full[i] <= 1'b0;
                end
                if (grant[i]) begin
                    inflight[i] <= 1'b1;
                end
                // The slot is empty here: its owner cannot issue while full.
                if (tag_out.valid && tag_out.id == BMU_ARB_ID_W'(i)) begin
                    rsp_full[i]  <= 1'b1;
                    inflight[i]  <= 1'b0;
                    rspResult[i] <= bmuResultFf;
                    rspError[i]  <= bmuError;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmu_arbiter.sv
// Self-checking bench for bmu_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_bmu_arbiter;

    localparam int N = 2;
    localparam int W = 42;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        reqValid = '0;
    logic [N-1:0]        reqReady;
    logic [N-1:0][W-1:0] reqAp = '0;
    logic [N-1:0][31:0]  reqA = '0;
    logic [N-1:0][31:0]  reqB = '0;
    logic [N-1:0]        reqCsrRen = '0;
    logic [N-1:0][31:0]  reqCsrRdata = '0;
    logic [N-1:0]        rspValid;
    logic [N-1:0]        rspReady = '0;
    logic [N-1:0][31:0]  rspResult;
    logic [N-1:0]        rspError;
    logic                bmuValidIn;
    logic [W-1:0]        bmuAp;
    logic [31:0]         bmuAIn;
    logic [31:0]         bmuBIn;
    logic                bmuCsrRenIn;
    logic [31:0]         bmuCsrRdataIn;
    logic                bmuScanMode;
    logic [31:0]         bmuResultFf = '0;
    logic                bmuError = 1'b0;

    bmu_arbiter #(
        .NUM_REQ(N),
        .BMU_LATENCY(1),
        .ALU_PKT_W(W)
    ) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqAp(reqAp),
        .reqA(reqA), .reqB(reqB), .reqCsrRen(reqCsrRen),
        .reqCsrRdata(reqCsrRdata), .rspValid(rspValid),
        .rspReady(rspReady), .rspResult(rspResult), .rspError(rspError),
        .bmuValidIn(bmuValidIn), .bmuAp(bmuAp), .bmuAIn(bmuAIn),
        .bmuBIn(bmuBIn), .bmuCsrRenIn(bmuCsrRenIn),
        .bmuCsrRdataIn(bmuCsrRdataIn), .bmuScanMode(bmuScanMode),
        .bmuResultFf(bmuResultFf), .bmuError(bmuError)
    );

    always #5 clk = ~clk;

    // BMU behaviour: ap[1:0] selects add/sub/xor/and, CSR read passes data,
    // ap[41] raises the error flag. Returns {error, result}.
    function automatic logic [32:0] bmu_f(logic [W-1:0] ap, logic [31:0] a,
                                          logic [31:0] b, logic ren,
                                          logic [31:0] rd);
        logic [31:0] r;
        if (ren) r = rd;
        else begin
            case (ap[1:0])
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a ^ b;
                default: r = a & b;
            endcase
        end
        return {ap[W-1], r};
    endfunction

    // One-cycle-latency BMU; garbage with error set when nothing was issued.
    logic [32:0] bmu_nx;
    always @(negedge clk) begin
        if (bmuValidIn)
            bmu_nx = bmu_f(bmuAp, bmuAIn, bmuBIn, bmuCsrRenIn, bmuCsrRdataIn);
        else
            bmu_nx = {1'b1, $urandom()};
        @(posedge clk);
        #1;
        {bmuError, bmuResultFf} = bmu_nx;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reqValid = '0;
        rspReady = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_op(int i, logic [W-1:0] ap, logic [31:0] a,
                          logic [31:0] b, logic ren, logic [31:0] rd);
        reqAp[i] = ap;
        reqA[i] = a;
        reqB[i] = b;
        reqCsrRen[i] = ren;
        reqCsrRdata[i] = rd;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_reqReady"}, 64'(reqReady), 0);
        chk({tag, "_rspValid"}, 64'(rspValid), 0);
        chk({tag, "_rspResult"}, 64'(rspResult), 0);
        chk({tag, "_rspError"}, 64'(rspError), 0);
        chk({tag, "_bmuValid"}, 64'(bmuValidIn), 0);
        chk({tag, "_bmuAp"}, 64'(bmuAp), 0);
        chk({tag, "_bmuA"}, 64'(bmuAIn), 0);
        chk({tag, "_bmuB"}, 64'(bmuBIn), 0);
        chk({tag, "_bmuRen"}, 64'(bmuCsrRenIn), 0);
        chk({tag, "_bmuRd"}, 64'(bmuCsrRdataIn), 0);
        chk({tag, "_scan"}, 64'(bmuScanMode), 0);
    endtask

    typedef struct {
        int           rq;
        logic [W-1:0] ap;
        logic [31:0]  a;
        logic [31:0]  b;
        logic         ren;
        logic [31:0]  rd;
        logic [31:0]  exp_r;
        logic         exp_e;
    } vec_t;

    vec_t vt[6];

    // Transaction-level model state for the random run.
    int           m_ptr;
    bit           m_out [N];
    int           m_due [N];
    logic [31:0]  m_res [N];
    logic         m_err [N];
    bit           m_pv;
    logic [W-1:0] m_ap;
    logic [31:0]  m_a, m_b, m_rd;
    logic         m_ren;
    bit           m_hold [N];
    logic [31:0]  m_held [N];

    initial begin
        int g;
        int cnt0, cnt1, g0;
        logic [N-1:0] exp_g [10];
        logic [32:0] fr;
        bit erv;

        vt[0] = '{0, 42'd0, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, 1'b0};
        vt[1] = '{1, 42'd1, 32'd10, 32'd3, 1'b0, 32'd0, 32'd7, 1'b0};
        vt[2] = '{0, 42'd2, 32'h0000F0F0, 32'h00000FF0, 1'b0, 32'd0,
                  32'h0000FF00, 1'b0};
        vt[3] = '{1, 42'd3, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'd0,
                  32'h0F000F00, 1'b0};
        vt[4] = '{0, {1'b1, 41'd0}, 32'd1, 32'd1, 1'b0, 32'd0, 32'd2, 1'b1};
        vt[5] = '{0, 42'd0, 32'd9, 32'd1, 1'b1, 32'hDEADBEEF,
                  32'hDEADBEEF, 1'b0};

        // Reset state
        #1;
        chk_all_zero("in_reset");
        do_reset();
        @(negedge clk);
        chk_all_zero("after_reset");
        tick();

        // Directed vectors: one op each, exact latency checks
        foreach (vt[v]) begin
            set_op(vt[v].rq, vt[v].ap, vt[v].a, vt[v].b, vt[v].ren, vt[v].rd);
            reqValid = N'(1 << vt[v].rq);
            @(negedge clk);
            chk("vec_ready", 64'(reqReady), 64'(1 << vt[v].rq));
            tick();
            reqValid = '0;
            @(negedge clk);
            chk("vec_bmu_valid", 64'(bmuValidIn), 1);
            chk("vec_bmu_ap", 64'(bmuAp), 64'(vt[v].ap));
            chk("vec_bmu_a", 64'(bmuAIn), 64'(vt[v].a));
            chk("vec_bmu_b", 64'(bmuBIn), 64'(vt[v].b));
            chk("vec_bmu_ren", 64'(bmuCsrRenIn), 64'(vt[v].ren));
            chk("vec_bmu_rd", 64'(bmuCsrRdataIn), 64'(vt[v].rd));
            tick();
            @(negedge clk);
            chk("vec_bmu_idle", 64'(bmuValidIn), 0);
            chk("vec_bmu_a_idle", 64'(bmuAIn), 0);
            chk("vec_rsp_early", 64'(rspValid), 0);
            tick();
            @(negedge clk);
            chk("vec_rsp_valid", 64'(rspValid), 64'(1 << vt[v].rq));
            chk("vec_rsp_result", 64'(rspResult[vt[v].rq]), 64'(vt[v].exp_r));
            chk("vec_rsp_error", 64'(rspError[vt[v].rq]), 64'(vt[v].exp_e));
            rspReady = N'(1 << vt[v].rq);
            tick();
            rspReady = '0;
        end

        // Alternating grants with both requesters always valid
        do_reset();
        set_op(0, 42'd0, 32'd3, 32'd4, 1'b0, 32'd0);
        set_op(1, 42'd1, 32'd20, 32'd5, 1'b0, 32'd0);
        exp_g = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00,
                  2'b01, 2'b10};
        reqValid = 2'b11;
        rspReady = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("alt_grant", 64'(reqReady), 64'(exp_g[c]));
            if (c > 0) begin
                chk("alt_bmu_valid", 64'(bmuValidIn), 64'(exp_g[c-1] != 0));
                if (exp_g[c-1] == 2'b01) chk("alt_bmu_a0", 64'(bmuAIn), 3);
                if (exp_g[c-1] == 2'b10) chk("alt_bmu_a1", 64'(bmuAIn), 20);
            end
            if (rspValid[0]) begin
                cnt0++;
                chk("alt_rsp0", 64'(rspResult[0]), 7);
                chk("alt_err0", 64'(rspError[0]), 0);
            end
            if (rspValid[1]) begin
                cnt1++;
                chk("alt_rsp1", 64'(rspResult[1]), 15);
                chk("alt_err1", 64'(rspError[1]), 0);
            end
            tick();
        end
        chk("alt_cnt0", 64'(cnt0), 2);
        chk("alt_cnt1", 64'(cnt1), 2);
        reqValid = '0;
        repeat (5) tick();

        // Backpressure on requester 1
        do_reset();
        set_op(1, 42'd2, 32'h0000AAAA, 32'h00005555, 1'b0, 32'd0);
        set_op(0, 42'd0, 32'd1, 32'd2, 1'b0, 32'd0);
        rspReady = 2'b01;
        reqValid = 2'b10;
        @(negedge clk);
        chk("bp_first_grant", 64'(reqReady), 2'b10);
        tick();
        reqValid = 2'b00;
        tick();
        tick();
        @(negedge clk);
        chk("bp_rsp_valid", 64'(rspValid), 2'b10);
        chk("bp_rsp_result", 64'(rspResult[1]), 32'h0000FFFF);
        g0 = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            reqValid = 2'b11;
            @(negedge clk);
            chk("bp_hold_valid", 64'(rspValid[1]), 1);
            chk("bp_hold_result", 64'(rspResult[1]), 32'h0000FFFF);
            chk("bp_no_grant1", 64'(reqReady[1]), 0);
            if (reqReady[0]) g0++;
        end
        chk("bp_req0_progress", 64'(g0 > 0), 1);
        tick();
        reqValid = 2'b10;
        rspReady = 2'b11;
        @(negedge clk);
        chk("bp_handshake_no_grant", 64'(reqReady[1]), 0);
        tick();
        rspReady = 2'b01;
        @(negedge clk);
        chk("bp_after_rsp_valid", 64'(rspValid[1]), 0);
        chk("bp_regrant", 64'(reqReady[1]), 1);
        tick();
        reqValid = '0;
        rspReady = 2'b11;
        repeat (6) tick();

        // Reset while an op is in the BMU
        do_reset();
        set_op(0, 42'd0, 32'd5, 32'd7, 1'b0, 32'd0);
        reqValid = 2'b01;
        @(negedge clk);
        chk("rst_grant", 64'(reqReady), 2'b01);
        tick();
        reqValid = '0;
        @(negedge clk);
        chk("rst_bmu_valid", 64'(bmuValidIn), 1);
        tick();
        rst = 1'b1;
        reqValid = 2'b11;
        #1;
        chk_all_zero("mid_reset");
        tick();
        rst = 1'b0;
        reqValid = '0;
        rspReady = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(rspValid), 0);
            chk("idle_valid", 64'(bmuValidIn), 0);
            chk("idle_ap", 64'(bmuAp), 0);
            chk("idle_a", 64'(bmuAIn), 0);
            chk("idle_b", 64'(bmuBIn), 0);
            chk("idle_rd", 64'(bmuCsrRdataIn), 0);
            chk("idle_scan", 64'(bmuScanMode), 0);
            tick();
        end
        reqValid = 2'b11;
        @(negedge clk);
        chk("rst_ptr_restart", 64'(reqReady), 2'b01);
        tick();
        reqValid = '0;

        // Randomized run against the model
        do_reset();
        m_ptr = 0;
        m_pv = 0;
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0;
            m_due[i] = 0;
            m_hold[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                reqValid[i] = ($urandom_range(0, 9) < 7);
                reqAp[i] = W'({$urandom(), $urandom()});
                reqA[i] = $urandom();
                reqB[i] = $urandom();
                reqCsrRen[i] = ($urandom_range(0, 4) == 0);
                reqCsrRdata[i] = $urandom();
                rspReady[i] = ($urandom_range(0, 9) < 6);
            end
            @(negedge clk);
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && reqValid[j] && !m_out[j]) g = j;
            end
            chk("rnd_grant", 64'(reqReady), (g >= 0) ? 64'(1 << g) : 0);
            chk("rnd_bmu_valid", 64'(bmuValidIn), 64'(m_pv));
            chk("rnd_bmu_ap", 64'(bmuAp), m_pv ? 64'(m_ap) : 0);
            chk("rnd_bmu_a", 64'(bmuAIn), m_pv ? 64'(m_a) : 0);
            chk("rnd_bmu_b", 64'(bmuBIn), m_pv ? 64'(m_b) : 0);
            chk("rnd_bmu_ren", 64'(bmuCsrRenIn), m_pv ? 64'(m_ren) : 0);
            chk("rnd_bmu_rd", 64'(bmuCsrRdataIn), m_pv ? 64'(m_rd) : 0);
            chk("rnd_scan", 64'(bmuScanMode), 0);
            for (int i = 0; i < N; i++) begin
                erv = m_out[i] && (c >= m_due[i]);
                chk("rnd_rsp_valid", 64'(rspValid[i]), 64'(erv));
                if (erv) begin
                    chk("rnd_rsp_result", 64'(rspResult[i]), 64'(m_res[i]));
                    chk("rnd_rsp_error", 64'(rspError[i]), 64'(m_err[i]));
                end
                // A parked response must never be overwritten.
                if (m_hold[i])
                    chk("rnd_slot_hold", 64'(rspResult[i]), 64'(m_held[i]));
                m_hold[i] = erv && !rspReady[i];
                m_held[i] = rspResult[i];
                if (erv && rspReady[i]) m_out[i] = 0;
            end
            m_pv = (g >= 0);
            if (g >= 0) begin
                m_ap = reqAp[g];
                m_a = reqA[g];
                m_b = reqB[g];
                m_ren = reqCsrRen[g];
                m_rd = reqCsrRdata[g];
                fr = bmu_f(m_ap, m_a, m_b, m_ren, m_rd);
                m_err[g] = fr[32];
                m_res[g] = fr[31:0];
                m_out[g] = 1;
                m_due[g] = c + 3;
                m_ptr = (g + 1) % N;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
